// File: rtl/lsu_ctrl_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : lsu_ctrl_if
// Brief  : Upstream pipeline and data-memory bus bundle for the LSU controller.
// Rev    : 1.0
// ----------------------------------------------------------------------------
interface lsu_ctrl_if #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 32
);
  logic              valid_i;
  logic              ready_o;
  logic [6:0]        opcode_i;
  logic [2:0]        funct3_i;
  logic [AWIDTH-1:0] addr_i;
  logic [DWIDTH-1:0] store_data_i;
  logic              dmem_req_o;
  logic              dmem_we_o;
  logic [AWIDTH-1:0] dmem_addr_o;
  logic [3:0]        dmem_be_o;
  logic [DWIDTH-1:0] dmem_wdata_o;
  logic              dmem_gnt_i;
  logic              dmem_rvalid_i;
  logic [DWIDTH-1:0] dmem_rdata_i;
  logic              done_o;
  logic              err_o;
  logic [DWIDTH-1:0] load_data_o;

  modport slave (
    input  valid_i, opcode_i, funct3_i, addr_i, store_data_i,
    input  dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i,
    output ready_o, dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o,
    output done_o, err_o, load_data_o
  );

  modport master (
    output valid_i, opcode_i, funct3_i, addr_i, store_data_i,
    output dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i,
    input  ready_o, dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o,
    input  done_o, err_o, load_data_o
  );
endinterface
`default_nettype wire

// File: rtl/lsu_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : lsu_ctrl
// Brief  : Memory-stage load/store controller, one req/gnt/rvalid access at a time.
// Rev    : 1.0
// ----------------------------------------------------------------------------
module lsu_ctrl #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 32
) (
  input  logic       clk,
  input  logic       reset,
  lsu_ctrl_if.slave  bus
);

  localparam logic [6:0] OPCODE_LOAD  = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE = 7'b0100011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [1:0]        off_q, off_d;
  logic              is_load_q, is_load_d;
  logic              err_flag_q, err_flag_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [3:0]        be_q, be_d;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic [DWIDTH-1:0] wdata_q, wdata_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [DWIDTH-1:0] load_data_q, load_data_d;

  logic              w_is_load, w_is_store, w_f3_legal, w_misalign, w_bad;
  logic [3:0]        w_be;
  logic [DWIDTH-1:0] w_wdata;
  logic [DWIDTH-1:0] w_shifted;
  logic [DWIDTH-1:0] w_extracted;

  // Decode of the incoming request; only consumed on an IDLE transfer.
  always_comb begin
    w_is_load  = (bus.opcode_i == OPCODE_LOAD);
    w_is_store = (bus.opcode_i == OPCODE_STORE);
    if (w_is_load) begin
      w_f3_legal = (bus.funct3_i != 3'b011) && (bus.funct3_i != 3'b110) &&
                   (bus.funct3_i != 3'b111);
    end else begin
      w_f3_legal = (bus.funct3_i < 3'b011);
    end
    w_misalign = ((bus.funct3_i[1:0] == 2'b01) && bus.addr_i[0]) ||
                 ((bus.funct3_i[1:0] == 2'b10) && (bus.addr_i[1:0] != 2'b00));
    w_bad      = !w_f3_legal || w_misalign;

    case (bus.funct3_i[1:0])
      2'b00: begin
        w_be    = 4'b0001 << bus.addr_i[1:0];
        w_wdata = {4{bus.store_data_i[7:0]}};
      end
      2'b01: begin
        w_be    = bus.addr_i[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{bus.store_data_i[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = bus.store_data_i;
      end
    endcase
    if (w_is_load) begin
      w_be = 4'b1111;
    end
  end

  always_comb begin
    w_shifted = bus.dmem_rdata_i >> {off_q, 3'b000};
    case (funct3_q)
      3'b000:  w_extracted = {{24{w_shifted[7]}}, w_shifted[7:0]};
      3'b001:  w_extracted = {{16{w_shifted[15]}}, w_shifted[15:0]};
      3'b100:  w_extracted = {24'd0, w_shifted[7:0]};
      3'b101:  w_extracted = {16'd0, w_shifted[15:0]};
      default: w_extracted = bus.dmem_rdata_i;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    funct3_d    = funct3_q;
    off_d       = off_q;
    is_load_d   = is_load_q;
    err_flag_d  = err_flag_q;
    req_d       = 1'b0;
    we_d        = 1'b0;
    be_d        = 4'b0000;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    load_data_d = load_data_q;

    case (state_q)
      IDLE: begin
        if (bus.valid_i && (w_is_load || w_is_store)) begin
          funct3_d   = bus.funct3_i;
          off_d      = bus.addr_i[1:0];
          is_load_d  = w_is_load;
          err_flag_d = w_bad;
          addr_d     = {bus.addr_i[AWIDTH-1:2], 2'b00};
          wdata_d    = w_wdata;
          if (w_bad) begin
            state_d = DONE;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else begin
            state_d = REQ;
            req_d   = 1'b1;
            we_d    = w_is_store;
            be_d    = w_be;
          end
        end
      end
      REQ: begin
        if (bus.dmem_gnt_i) begin
          if (is_load_q) begin
            state_d = WAIT;
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
            err_d   = err_flag_q;
          end
        end else begin
          req_d = 1'b1;
          we_d  = we_q;
          be_d  = be_q;
        end
      end
      WAIT: begin
        if (bus.dmem_rvalid_i) begin
          state_d     = DONE;
          done_d      = 1'b1;
          err_d       = err_flag_q;
          load_data_d = w_extracted;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      funct3_q    <= 3'd0;
      off_q       <= 2'd0;
      is_load_q   <= 1'b0;
      err_flag_q  <= 1'b0;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      be_q        <= 4'd0;
      addr_q      <= '0;
      wdata_q     <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      load_data_q <= '0;
    end else begin
      state_q     <= state_d;
      funct3_q    <= funct3_d;
      off_q       <= off_d;
      is_load_q   <= is_load_d;
      err_flag_q  <= err_flag_d;
      req_q       <= req_d;
      we_q        <= we_d;
      be_q        <= be_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      done_q      <= done_d;
      err_q       <= err_d;
      load_data_q <= load_data_d;
    end
  end

  assign bus.ready_o      = (state_q == IDLE) && !reset;
  assign bus.dmem_req_o   = req_q;
  assign bus.dmem_we_o    = we_q;
  assign bus.dmem_be_o    = be_q;
  assign bus.dmem_addr_o  = addr_q;
  assign bus.dmem_wdata_o = wdata_q;
  assign bus.done_o       = done_q;
  assign bus.err_o        = err_q;
  assign bus.load_data_o  = load_data_q;

endmodule
`default_nettype wire

// File: tb/tb_lsu_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : tb_lsu_ctrl
// Brief  : Randomised self-checking bench for lsu_ctrl against a behavioural model.
// Rev    : 1.0
// ----------------------------------------------------------------------------
module tb_lsu_ctrl;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  lsu_ctrl_if #(.DWIDTH(32), .AWIDTH(32)) bus ();

  lsu_ctrl #(.DWIDTH(32), .AWIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] last_load;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference behaviour expressed in terms of access size in bytes and byte offset.
  function automatic void model(
    input  logic [6:0]  op,
    input  logic [2:0]  f3,
    input  logic [31:0] addr,
    input  logic [31:0] sd,
    input  logic [31:0] rdata,
    output logic        is_ls,
    output logic        is_ld,
    output logic        err,
    output logic [3:0]  be,
    output logic [31:0] wd,
    output logic [31:0] ld
  );
    int          nbytes;
    int          off;
    logic        legal;
    logic [31:0] lane;
    is_ld  = (op == OP_LOAD);
    is_ls  = is_ld || (op == OP_STORE);
    nbytes = 1 << (int'(f3) % 4);
    off    = int'(addr % 4);
    legal  = is_ld ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (f3 <= 3'd2);
    err    = !legal || ((addr % nbytes) != 0);
    be     = 4'hF;
    wd     = sd;
    if (!is_ld) begin
      if (nbytes == 1) begin
        be = 4'(1 << off);
        wd = {24'd0, sd[7:0]} * 32'h01010101;
      end else if (nbytes == 2) begin
        be = (off >= 2) ? 4'hC : 4'h3;
        wd = {16'd0, sd[15:0]} * 32'h00010001;
      end
    end
    lane = rdata >> (8 * off);
    ld   = rdata;
    if (nbytes == 1) begin
      ld = lane & 32'hFF;
      if (f3 < 3'd4 && lane[7]) ld = ld | 32'hFFFFFF00;
    end else if (nbytes == 2) begin
      ld = lane & 32'hFFFF;
      if (f3 < 3'd4 && lane[15]) ld = ld | 32'hFFFF0000;
    end
  endfunction

  task automatic run_txn(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] sd, input int stall, input int delay,
                         input logic [31:0] rdata);
    int          w;
    logic        is_ls, is_ld, err;
    logic [3:0]  be;
    logic [31:0] wd, ld;
    w = 0;
    while (!bus.ready_o && w < 8) begin
      @(negedge clk);
      w++;
    end
    if (!bus.ready_o) begin
      chk("ready_timeout", 32'(bus.ready_o), 32'd1);
      return;
    end
    model(op, f3, addr, sd, rdata, is_ls, is_ld, err, be, wd, ld);
    bus.valid_i      = 1'b1;
    bus.opcode_i     = op;
    bus.funct3_i     = f3;
    bus.addr_i       = addr;
    bus.store_data_i = sd;
    @(negedge clk);
    bus.valid_i      = 1'b0;
    bus.opcode_i     = 7'($urandom);
    bus.funct3_i     = 3'($urandom);
    bus.addr_i       = $urandom;
    bus.store_data_i = $urandom;
    if (!is_ls) begin
      chk("nop_ready", 32'(bus.ready_o), 32'd1);
      chk("nop_req", 32'(bus.dmem_req_o), 32'd0);
      chk("nop_done", 32'(bus.done_o), 32'd0);
      return;
    end
    if (err) begin
      chk("err_done", 32'(bus.done_o), 32'd1);
      chk("err_flag", 32'(bus.err_o), 32'd1);
      chk("err_req", 32'(bus.dmem_req_o), 32'd0);
      chk("err_ld", bus.load_data_o, last_load);
      @(negedge clk);
      chk("err_done_clr", 32'(bus.done_o), 32'd0);
      chk("err_req2", 32'(bus.dmem_req_o), 32'd0);
      return;
    end
    for (int k = 0; k <= stall; k++) begin
      chk("req", 32'(bus.dmem_req_o), 32'd1);
      chk("we", 32'(bus.dmem_we_o), 32'(!is_ld));
      chk("addr", bus.dmem_addr_o, addr & ~32'h3);
      chk("be", 32'(bus.dmem_be_o), 32'(be));
      if (!is_ld) chk("wdata", bus.dmem_wdata_o, wd);
      chk("req_done", 32'(bus.done_o), 32'd0);
      bus.dmem_gnt_i    = (k == stall);
      bus.dmem_rvalid_i = 1'($urandom);
      bus.dmem_rdata_i  = $urandom;
      @(negedge clk);
    end
    bus.dmem_gnt_i    = 1'b0;
    bus.dmem_rvalid_i = 1'b0;
    if (is_ld) begin
      for (int d = 0; d <= delay; d++) begin
        chk("wait_req", 32'(bus.dmem_req_o), 32'd0);
        chk("wait_done", 32'(bus.done_o), 32'd0);
        chk("wait_ld", bus.load_data_o, last_load);
        bus.dmem_rvalid_i = (d == delay);
        bus.dmem_rdata_i  = (d == delay) ? rdata : $urandom;
        @(negedge clk);
      end
      bus.dmem_rvalid_i = 1'b0;
    end
    chk("done", 32'(bus.done_o), 32'd1);
    chk("done_err", 32'(bus.err_o), 32'd0);
    chk("done_req", 32'(bus.dmem_req_o), 32'd0);
    chk("done_ready", 32'(bus.ready_o), 32'd0);
    if (is_ld) last_load = ld;
    chk("load_data", bus.load_data_o, last_load);
    @(negedge clk);
    chk("done_clr", 32'(bus.done_o), 32'd0);
  endtask

  initial begin
    logic [6:0] op;
    logic [2:0] f3;
    int         r;
    reset             = 1'b1;
    bus.valid_i       = 1'b0;
    bus.opcode_i      = 7'd0;
    bus.funct3_i      = 3'd0;
    bus.addr_i        = 32'd0;
    bus.store_data_i  = 32'd0;
    bus.dmem_gnt_i    = 1'b0;
    bus.dmem_rvalid_i = 1'b0;
    bus.dmem_rdata_i  = 32'd0;
    last_load         = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(bus.ready_o), 32'd0);
    chk("rst_req", 32'(bus.dmem_req_o), 32'd0);
    chk("rst_we", 32'(bus.dmem_we_o), 32'd0);
    chk("rst_be", 32'(bus.dmem_be_o), 32'd0);
    chk("rst_addr", bus.dmem_addr_o, 32'd0);
    chk("rst_wdata", bus.dmem_wdata_o, 32'd0);
    chk("rst_done", 32'(bus.done_o), 32'd0);
    chk("rst_err", 32'(bus.err_o), 32'd0);
    chk("rst_ld", bus.load_data_o, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_ready", 32'(bus.ready_o), 32'd1);

    run_txn(OP_STORE, 3'b010, 32'h100, 32'hDEADBEEF, 0, 0, 32'd0);
    run_txn(OP_STORE, 3'b000, 32'h103, 32'h000000A5, 0, 0, 32'd0);
    run_txn(OP_STORE, 3'b001, 32'h102, 32'h00001234, 1, 0, 32'd0);
    run_txn(OP_LOAD,  3'b000, 32'h201, 32'd0, 3, 1, 32'h00008000);
    chk("lb_const", bus.load_data_o, 32'hFFFFFF80);
    run_txn(OP_LOAD,  3'b100, 32'h201, 32'd0, 3, 1, 32'h00008000);
    chk("lbu_const", bus.load_data_o, 32'h00000080);
    run_txn(OP_LOAD,  3'b001, 32'h202, 32'd0, 0, 0, 32'h80010000);
    chk("lh_const", bus.load_data_o, 32'hFFFF8001);
    run_txn(OP_LOAD,  3'b010, 32'h102, 32'd0, 0, 0, 32'd0);
    run_txn(OP_LOAD,  3'b011, 32'h200, 32'd0, 0, 0, 32'd0);
    run_txn(OP_STORE, 3'b011, 32'h200, 32'd0, 0, 0, 32'd0);
    run_txn(OP_RTYPE, 3'b000, 32'h200, 32'd0, 0, 0, 32'd0);

    for (int i = 0; i < 80; i++) begin
      r  = int'($urandom % 8);
      op = (r == 0) ? OP_RTYPE : (r[0] ? OP_LOAD : OP_STORE);
      f3 = ($urandom % 4 == 0) ? 3'($urandom) : 3'($urandom % 3);
      run_txn(op, f3, $urandom, $urandom, int'($urandom % 4), int'($urandom % 4), $urandom);
    end

    // Reset while waiting for read data; the late rvalid must not land.
    run_txn(OP_LOAD, 3'b010, 32'h300, 32'd0, 0, 0, 32'h13572468);
    bus.valid_i  = 1'b1;
    bus.opcode_i = OP_LOAD;
    bus.funct3_i = 3'b010;
    bus.addr_i   = 32'h400;
    @(negedge clk);
    bus.valid_i    = 1'b0;
    bus.dmem_gnt_i = 1'b1;
    @(negedge clk);
    bus.dmem_gnt_i = 1'b0;
    chk("rw_wait_req", 32'(bus.dmem_req_o), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("rw_ready_rst", 32'(bus.ready_o), 32'd0);
    chk("rw_ld_rst", bus.load_data_o, 32'd0);
    reset             = 1'b0;
    bus.dmem_rvalid_i = 1'b1;
    bus.dmem_rdata_i  = 32'hCAFEF00D;
    @(negedge clk);
    bus.dmem_rvalid_i = 1'b0;
    last_load         = 32'd0;
    chk("rw_ready", 32'(bus.ready_o), 32'd1);
    chk("rw_done", 32'(bus.done_o), 32'd0);
    chk("rw_ld", bus.load_data_o, 32'd0);
    @(negedge clk);
    chk("rw_done2", 32'(bus.done_o), 32'd0);
    chk("rw_ld2", bus.load_data_o, 32'd0);
    run_txn(OP_LOAD, 3'b101, 32'h402, 32'd0, 1, 2, 32'hBEEF1234);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store unit controller in the memory stage. It takes the effective address computed by the execute-stage ALU, the load/store opcode and funct3, and the rs2 store data. It runs one data-memory transaction over a req/gnt/rvalid handshake, and returns aligned, sign/zero-extended load data for writeback. One transaction is in flight at a time; the upstream stage is back-pressured through `ready_o`.

## Interface
- `DWIDTH`, 32, data width (only 32 supported)
- `AWIDTH`, 32, address width
- `clk`  in  1  single clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high reset
- `valid_i`  in  1  upstream presents an instruction
- `ready_o`  out  1  unit can accept; transfer when `valid_i && ready_o`
- `opcode_i`  in  7  instruction opcode (OPCODE_LOAD / OPCODE_STORE act; others ignored)
- `funct3_i`  in  3  access size/sign (LB/LH/LW/LBU/LHU, SB/SH/SW)
- `addr_i`  in  AWIDTH  effective byte address (ALU result)
- `store_data_i`  in  DWIDTH  rs2 value for stores
- `dmem_req_o`  out  1  memory request valid
- `dmem_we_o`  out  1  1 = write, 0 = read
- `dmem_addr_o`  out  AWIDTH  word-aligned address (`addr[AWIDTH-1:2]`, low bits 0)
- `dmem_be_o`  out  4  byte enables (writes); 4'b1111 on reads
- `dmem_wdata_o`  out  DWIDTH  lane-replicated store data
- `dmem_gnt_i`  in  1  request accepted this cycle
- `dmem_rvalid_i`  in  1  read data valid
- `dmem_rdata_i`  in  DWIDTH  read word
- `done_o`  out  1  one-cycle completion pulse
- `err_o`  out  1  valid with `done_o`: misaligned or illegal funct3, no memory access made
- `load_data_o`  out  DWIDTH  extended load result, registered, held until the next load completes

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - `ready_o=1` (forced 0 while `reset` is high).
  - On a transfer with a load/store opcode: latch opcode, funct3, `addr_i[1:0]`, address and store data.
    - If the access is illegal or misaligned: set the error flag and go to DONE.
    - Otherwise go to REQ.
  - A transfer with any other opcode is consumed silently: no state change, no `done_o`.
- Illegal funct3: loads 3'b011, 3'b110, 3'b111; stores ≥ 3'b011.
- Misaligned: halfword with `addr[0]=1`; word with `addr[1:0]≠0`. Byte accesses are always aligned.
- REQ:
  - `dmem_req_o=1`; addr/we/be/wdata driven from latched values and held stable until grant.
  - On `dmem_gnt_i`: a store goes to DONE, a load goes to WAIT.
- WAIT:
  - `dmem_req_o=0`.
  - On `dmem_rvalid_i`: capture the extracted data into `load_data_o`, go to DONE.
  - `dmem_rvalid_i` is sampled only in WAIT and ignored in every other state.
- DONE: `done_o=1` (`err_o` = error flag), `ready_o=0`; next state IDLE.
- Store lane rules:
  - SB: `be = 4'b0001 << addr[1:0]`, `wdata = {4{data[7:0]}}`.
  - SH: `be = addr[1] ? 4'b1100 : 4'b0011`, `wdata = {2{data[15:0]}}`.
  - SW: `be = 4'b1111`, `wdata = data`.
- Load extraction:
  - Shift `dmem_rdata_i` right by `8*addr[1:0]`.
  - LB/LH sign-extend bit 7/15; LBU/LHU zero-extend; LW passes the word.
- Reset (any state, including REQ or WAIT mid-transaction):
  - Next state IDLE.
  - Clear error flag, `done_o=0`, `err_o=0`, `dmem_req_o=0`, `load_data_o=0`, latched registers 0.
  - Any in-flight grant or later rvalid is dropped.

## Timing
- Reset values: `ready_o=0` during reset, then 1 in IDLE. `dmem_req_o=0`, `dmem_we_o=0`, `dmem_be_o=0`, `dmem_addr_o=0`, `dmem_wdata_o=0`, `done_o=0`, `err_o=0`, `load_data_o=0`.
- Cycle numbering: accept at cycle T; REQ at T+1.
- Store, grant in the same cycle as request: `done_o` at T+2.
- Load, grant at T+1 and rvalid at T+2: `done_o` and new `load_data_o` visible at T+3.
- Each cycle of grant stall or rvalid delay adds one cycle.
- Error path: `done_o=err_o=1` at T+1; `dmem_req_o` never asserted.
- Throughput: back-to-back accesses accepted at best every 3 cycles (store) / 4 cycles (load).
- `dmem_*` outputs are 0 outside REQ, except `dmem_addr_o`/`dmem_wdata_o`, which may hold their latched values.
- `load_data_o` changes only in the cycle entering DONE from WAIT.

## Test plan
- Store SW, addr 0x100, data 0xDEADBEEF, `dmem_gnt_i` tied 1 -> req at T+1 with we=1, addr 0x100, be 4'b1111, wdata 0xDEADBEEF; `done_o` at T+2, `err_o=0`.
- Store SB, addr 0x103, data 0x000000A5 -> be 4'b1000, wdata 0xA5A5A5A5. SH, addr 0x102, data 0x1234 -> be 4'b1100, wdata 0x12341234.
- Load LB, addr 0x201, rdata 0x0000_80_00 returned 2 cycles after a grant that was stalled 3 cycles -> `load_data_o=0xFFFFFF80`. Same access as LBU -> 0x00000080. LH at 0x202 with rdata 0x8001_0000 -> 0xFFFF8001.
- Misaligned LW at 0x102 and illegal load funct3 3'b011 -> `done_o=err_o=1` at T+1, `dmem_req_o` never high, `load_data_o` unchanged.
- Opcode OPCODE_R_TYPE with `valid_i=1` -> `ready_o` stays 1, no `dmem_req_o`, no `done_o`.
- Reset asserted in WAIT, rvalid arrives the cycle after reset deasserts -> unit in IDLE, `ready_o=1`, `load_data_o=0`, no `done_o`; rvalid ignored.
